// File: rtl/bf16_to_bcd.sv
// BF16 to signed 4-digit packed BCD formatter for the 7-segment display path.
// Rounds half away from zero, then runs a one-shift-per-clock double-dabble engine.
module bf16_to_bcd #(
    parameter int MAXVAL = 9999,
    parameter int BINW   = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] val,
    input  logic        err_in,
    output logic        sign,
    output logic [15:0] bcd,
    output logic        error,
    output logic        done,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(BINW);
    localparam logic [CW-1:0] LAST = CW'(BINW - 1);
    localparam logic [15:0] MAXV = 16'(MAXVAL);

    typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, DONE_ST} state_t;
    state_t state, state_d;

    logic [15:0]     val_q, val_d;
    logic            err_q, err_d;
    logic [BINW-1:0] bin_q, bin_d;
    logic [15:0]     acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sgn_q, sgn_d;
    logic            sign_d, error_d, done_d;
    logic [15:0]     bcd_d;

    logic [7:0]  e;
    logic [7:0]  sig;
    logic [7:0]  sh;
    logic [15:0] mag;
    logic        ovf;
    logic [15:0] adj;
    logic [15:0] shifted;

    assign dbg_state = state;
    assign e   = val_q[14:7];
    assign sig = {1'b1, val_q[6:0]};

    // Rounded magnitude of the captured value; ovf covers Inf/NaN and out-of-range.
    always_comb begin
        mag = '0;
        ovf = 1'b0;
        sh  = '0;
        if (e < 8'd126) begin
            mag = '0;
        end else if (e == 8'd126) begin
            mag = 16'd1;
        end else if (e <= 8'd133) begin
            sh  = 8'd134 - e;
            mag = ({8'd0, sig} + (16'd1 << (sh - 8'd1))) >> sh;
        end else if (e <= 8'd140) begin
            mag = {8'd0, sig} << (e - 8'd134);
        end else begin
            ovf = 1'b1;
        end
        if (mag > MAXV) ovf = 1'b1;
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj[14:0], bin_q[BINW-1]};
    end

    always_comb begin
        state_d = state;
        val_d   = val_q;
        err_d   = err_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        sign_d  = sign;
        bcd_d   = bcd;
        error_d = error;
        done_d  = done;
        case (state)
            IDLE: begin
                done_d  = 1'b0;
                error_d = 1'b0;
                if (start) begin
                    val_d   = val;
                    err_d   = err_in;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (err_q || e == 8'hFF || ovf) begin
                    error_d = 1'b1;
                    bcd_d   = '0;
                    sign_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE_ST;
                end else begin
                    bin_d   = mag[BINW-1:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                    sgn_d   = val_q[15] & (mag != 16'd0);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shifted;
                bin_d = {bin_q[BINW-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bcd_d   = shifted;
                    sign_d  = sgn_q;
                    error_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                if (!start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            val_q <= '0;
            err_q <= 1'b0;
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            sgn_q <= 1'b0;
            sign  <= 1'b0;
            bcd   <= '0;
            error <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            val_q <= val_d;
            err_q <= err_d;
            bin_q <= bin_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sgn_q <= sgn_d;
            sign  <= sign_d;
            bcd   <= bcd_d;
            error <= error_d;
            done  <= done_d;
        end
    end
endmodule

// File: tb/tb_bf16_to_bcd.sv
// Table-driven bench for bf16_to_bcd with an expected-result queue and latency checks.
module tb_bf16_to_bcd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] val = '0;
    logic        err_in = 1'b0;
    logic        sign;
    logic [15:0] bcd;
    logic        error;
    logic        done;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] v;
        logic        ei;
        logic        s;
        logic [15:0] b;
        logic        er;
        int          lat;
    } vec_t;

    vec_t vecs[17];
    logic [17:0] exp_q[$];
    int          lat_q[$];

    bf16_to_bcd #(.MAXVAL(9999), .BINW(14)) dut (
        .clk(clk), .rst(rst), .start(start), .val(val), .err_in(err_in),
        .sign(sign), .bcd(bcd), .error(error), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: one full conversion with start held until done, then released
    task automatic run_conv(input logic [15:0] v, input logic ei, input logic s,
                            input logic [15:0] b, input logic er, input int lat);
        logic [17:0] exp_r;
        int          exp_lat;
        int          edges;
        exp_q.push_back({s, er, b});
        lat_q.push_back(lat);
        val = v;
        err_in = ei;
        start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done && edges < 40);
        exp_r = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        check($sformatf("latency %h", v), edges, exp_lat);
        check($sformatf("sign %h", v), {31'd0, sign}, {31'd0, exp_r[17]});
        check($sformatf("error %h", v), {31'd0, error}, {31'd0, exp_r[16]});
        check($sformatf("bcd %h", v), {16'd0, bcd}, {16'd0, exp_r[15:0]});
        @(posedge clk); #1;
        check($sformatf("done_held %h", v), {31'd0, done}, 32'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check($sformatf("done_drop %h", v), {31'd0, done}, 32'd0);
        check($sformatf("error_drop %h", v), {31'd0, error}, 32'd0);
        check($sformatf("bcd_kept %h", v), {16'd0, bcd}, {16'd0, exp_r[15:0]});
    endtask

    initial begin
        int   edges;
        int   rises;
        logic prev_done;

        vecs[0]  = '{16'h42B4, 1'b0, 1'b0, 16'h0090, 1'b0, 16};
        vecs[1]  = '{16'h4334, 1'b0, 1'b0, 16'h0180, 1'b0, 16};
        vecs[2]  = '{16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16};
        vecs[3]  = '{16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, 16};
        vecs[4]  = '{16'hC020, 1'b0, 1'b1, 16'h0003, 1'b0, 16};
        vecs[5]  = '{16'h3F00, 1'b0, 1'b0, 16'h0001, 1'b0, 16};
        vecs[6]  = '{16'h3ECD, 1'b0, 1'b0, 16'h0000, 1'b0, 16};
        vecs[7]  = '{16'h461C, 1'b0, 1'b0, 16'h9984, 1'b0, 16};
        vecs[8]  = '{16'hFFC0, 1'b0, 1'b0, 16'h0000, 1'b1, 2};
        vecs[9]  = '{16'h461D, 1'b0, 1'b0, 16'h0000, 1'b1, 2};
        vecs[10] = '{16'h42B4, 1'b1, 1'b0, 16'h0000, 1'b1, 2};
        vecs[11] = '{16'h7F80, 1'b0, 1'b0, 16'h0000, 1'b1, 2};
        vecs[12] = '{16'h4780, 1'b0, 1'b0, 16'h0000, 1'b1, 2};
        vecs[13] = '{16'hC2B4, 1'b0, 1'b1, 16'h0090, 1'b0, 16};
        vecs[14] = '{16'hBF00, 1'b0, 1'b1, 16'h0001, 1'b0, 16};
        vecs[15] = '{16'h4479, 1'b0, 1'b0, 16'h0996, 1'b0, 16};
        vecs[16] = '{16'hBECD, 1'b0, 1'b0, 16'h0000, 1'b0, 16};

        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_bcd", {16'd0, bcd}, 32'd0);
        check("reset_error_sign", {30'd0, error, sign}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++)
            run_conv(vecs[i].v, vecs[i].ei, vecs[i].s, vecs[i].b, vecs[i].er, vecs[i].lat);

        // reset during SHIFT: previous bcd (0x0000) so first load a visible value
        run_conv(16'h461C, 1'b0, 1'b0, 16'h9984, 1'b0, 16);
        val = 16'h4334;
        start = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_bcd", {16'd0, bcd}, 32'd0);
        check("rst_mid_flags", {29'd0, done, error, sign}, 32'd0);
        check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_conv(16'h4334, 1'b0, 1'b0, 16'h0180, 1'b0, 16);

        // captured operands survive input toggling and a mid-conversion start pulse
        val = 16'h42B4;
        err_in = 1'b0;
        start = 1'b1;
        edges = 0;
        rises = 0;
        prev_done = 1'b0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 4) begin val = 16'hFFC0; err_in = 1'b1; end
            if (edges == 6) start = 1'b0;
            if (edges == 8) start = 1'b1;
            if (edges == 10) val = 16'h461D;
            if (done && !prev_done) rises++;
            prev_done = done;
        end while (!done && edges < 40);
        check("toggle_latency", edges, 32'd16);
        check("toggle_bcd", {16'd0, bcd}, 32'h0090);
        check("toggle_error", {31'd0, error}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            if (done && !prev_done) rises++;
            prev_done = done;
        end
        check("toggle_done_held", {31'd0, done}, 32'd1);
        check("toggle_one_done", rises, 32'd1);
        start = 1'b0;
        err_in = 1'b0;
        @(posedge clk); #1;
        check("toggle_done_drop", {31'd0, done}, 32'd0);
        check("toggle_bcd_kept", {16'd0, bcd}, 32'h0090);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
